// File: rtl/word_unpacker.sv
// word_unpacker: takes 32-bit words from the byte-to-word queue and re-emits
// them as four bytes per word. A one-word prefetch register lets the next
// word be fetched while the current one drains, so bytes stream without gaps.
module word_unpacker #(
  parameter int WORD_W    = 32,
  parameter int BYTE_W    = 8,
  parameter int LSB_FIRST = 1,
  parameter int CNT_W     = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WORD_W-1:0] Data_Q,
  input  logic              Q_VALID,
  output logic              Q_READY,
  output logic [BYTE_W-1:0] BYTE_OUT,
  output logic              B_VALID,
  input  logic              B_READY,
  output logic              BUSY,
  output logic [CNT_W-1:0]  WORD_CNT
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state, state_nx;
  logic [WORD_W-1:0] sr, sr_nx;
  logic [WORD_W-1:0] pf, pf_nx;
  logic              pf_full, pf_full_nx;
  logic [1:0]        idx, idx_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              q_ready;
  logic              accept;
  logic              xfer;

  // Pick byte lane i of a word; with LSB_FIRST=0 the lane order is reversed
  // (~i equals 3-i for a 2-bit index).
  function automatic logic [BYTE_W-1:0] lane_sel(input logic [WORD_W-1:0] w,
                                                 input logic [1:0]        i);
    logic [1:0]        lane;
    logic [BYTE_W-1:0] b;
    lane = (LSB_FIRST != 0) ? i : ~i;
    case (lane)
      2'd0:    b = w[BYTE_W-1:0];
      2'd1:    b = w[2*BYTE_W-1:BYTE_W];
      2'd2:    b = w[3*BYTE_W-1:2*BYTE_W];
      default: b = w[4*BYTE_W-1:3*BYTE_W];
    endcase
    return b;
  endfunction

  // Handshake events; Q_READY is registered, so accept never depends on the
  // sink side combinationally.
  always_comb begin
    accept = Q_VALID && q_ready;
    xfer   = (state == SEND) && B_READY;
  end

  // Next-state logic: byte lane advance, word reload from PF or the queue,
  // and prefetch capture of words that arrive while a word is in flight.
  always_comb begin
    state_nx   = state;
    sr_nx      = sr;
    pf_nx      = pf;
    pf_full_nx = pf_full;
    idx_nx     = idx;
    cnt_nx     = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          sr_nx    = Data_Q;
          idx_nx   = 2'd0;
          state_nx = SEND;
        end
      end
      default: begin
        if (xfer && (idx == 2'd3)) begin
          cnt_nx = cnt + CNT_W'(1);
          if (pf_full) begin
            // Prefetched word takes priority; a same-edge accept refills PF.
            sr_nx  = pf;
            idx_nx = 2'd0;
            if (accept) begin
              pf_nx      = Data_Q;
              pf_full_nx = 1'b1;
            end else begin
              pf_full_nx = 1'b0;
            end
          end else if (accept) begin
            sr_nx  = Data_Q;
            idx_nx = 2'd0;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          if (xfer) begin
            idx_nx = idx + 2'd1;
          end
          if (accept) begin
            pf_nx      = Data_Q;
            pf_full_nx = 1'b1;
          end
        end
      end
    endcase
  end

  // State and storage registers; reset discards any word in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      sr      <= '0;
      pf      <= '0;
      pf_full <= 1'b0;
      idx     <= 2'd0;
      cnt     <= '0;
      q_ready <= 1'b0;
    end else begin
      state   <= state_nx;
      sr      <= sr_nx;
      pf      <= pf_nx;
      pf_full <= pf_full_nx;
      idx     <= idx_nx;
      cnt     <= cnt_nx;
      q_ready <= !pf_full_nx;
    end
  end

  // Output decode; BYTE_OUT is forced to zero whenever no byte is offered.
  always_comb begin
    B_VALID  = (state == SEND);
    BYTE_OUT = B_VALID ? lane_sel(sr, idx) : '0;
    BUSY     = B_VALID || pf_full;
    Q_READY  = q_ready;
    WORD_CNT = cnt;
  end

endmodule

// File: tb/tb_word_unpacker.sv
// Testbench for word_unpacker: two instances share stimulus, one LSB-first
// with a 16-bit word counter and one MSB-first with a 2-bit counter so that
// counter wrap is exercised often. A byte-queue model predicts all outputs.
module tb_word_unpacker;

  logic        CLK;
  logic        RST;
  logic [31:0] Data_Q;
  logic        Q_VALID;
  logic        B_READY;
  logic        Q_READY, Q_READY2;
  logic [7:0]  BYTE_OUT, BYTE_OUT2;
  logic        B_VALID, B_VALID2;
  logic        BUSY, BUSY2;
  logic [15:0] WORD_CNT;
  logic [1:0]  WORD_CNT2;

  int checks = 0;
  int errors = 0;

  word_unpacker #(.WORD_W(32), .BYTE_W(8), .LSB_FIRST(1), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .Data_Q(Data_Q), .Q_VALID(Q_VALID), .Q_READY(Q_READY),
    .BYTE_OUT(BYTE_OUT), .B_VALID(B_VALID), .B_READY(B_READY), .BUSY(BUSY),
    .WORD_CNT(WORD_CNT)
  );

  word_unpacker #(.WORD_W(32), .BYTE_W(8), .LSB_FIRST(0), .CNT_W(2)) dut2 (
    .CLK(CLK), .RST(RST), .Data_Q(Data_Q), .Q_VALID(Q_VALID), .Q_READY(Q_READY2),
    .BYTE_OUT(BYTE_OUT2), .B_VALID(B_VALID2), .B_READY(B_READY), .BUSY(BUSY2),
    .WORD_CNT(WORD_CNT2)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: every accepted word becomes four queued bytes in send
  // order; a byte leaves the queue on each transfer.
  logic [7:0]  q1[$];
  logic [7:0]  q2[$];
  int          bytes_out = 0;
  int unsigned wc = 0;
  bit          fresh = 1'b1;

  always @(negedge CLK) begin
    logic       exp_valid;
    logic       exp_rdy;
    logic [7:0] tmp;
    if (!RST) begin
      q1.delete();
      q2.delete();
      bytes_out = 0;
      wc        = 0;
      fresh     = 1'b1;
      chk("rst_bvalid", {31'd0, B_VALID}, 32'd0);
      chk("rst_qready", {31'd0, Q_READY}, 32'd0);
      chk("rst_busy", {31'd0, BUSY}, 32'd0);
      chk("rst_cnt", {16'd0, WORD_CNT}, 32'd0);
      chk("rst_byte", {24'd0, BYTE_OUT}, 32'd0);
    end else begin
      exp_valid = (q1.size() > 0);
      // The prefetch slot is full exactly when more than one word's bytes wait.
      exp_rdy   = fresh ? 1'b0 : (q1.size() <= 4);
      chk("m_bvalid", {31'd0, B_VALID}, {31'd0, exp_valid});
      chk("m_bvalid2", {31'd0, B_VALID2}, {31'd0, exp_valid});
      chk("m_busy", {31'd0, BUSY}, {31'd0, exp_valid});
      chk("m_qready", {31'd0, Q_READY}, {31'd0, exp_rdy});
      chk("m_qready2", {31'd0, Q_READY2}, {31'd0, exp_rdy});
      chk("m_cnt", {16'd0, WORD_CNT}, wc % 65536);
      chk("m_cnt2", {30'd0, WORD_CNT2}, wc % 4);
      if (exp_valid) begin
        chk("m_byte", {24'd0, BYTE_OUT}, {24'd0, q1[0]});
        chk("m_byte2", {24'd0, BYTE_OUT2}, {24'd0, q2[0]});
      end
      if (exp_valid && B_READY) begin
        tmp = q1.pop_front();
        tmp = q2.pop_front();
        bytes_out++;
        if (bytes_out % 4 == 0) wc++;
      end
      if (Q_VALID && exp_rdy) begin
        for (int l = 0; l < 4; l++) begin
          q1.push_back(Data_Q[8*l +: 8]);
          q2.push_back(Data_Q[8*(3-l) +: 8]);
        end
      end
      fresh = 1'b0;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [31:0] w[3];
  logic [7:0]  exp_b[4];
  logic [7:0]  exp_b2[4];
  int          k;
  bit          acc;

  initial begin
    RST     = 1'b0;
    Q_VALID = 1'b0;
    B_READY = 1'b0;
    Data_Q  = 32'h0;
    tick();
    tick();
    chk("reset_qready", {31'd0, Q_READY}, 32'd0);
    chk("reset_bvalid", {31'd0, B_VALID}, 32'd0);
    RST = 1'b1;
    chk("pre_edge_qready", {31'd0, Q_READY}, 32'd0);
    tick();
    chk("post_rel_qready", {31'd0, Q_READY}, 32'd1);

    // Single word, both lane orders.
    B_READY = 1'b1;
    Data_Q  = 32'hA1B2C3D4;
    Q_VALID = 1'b1;
    tick();
    Q_VALID = 1'b0;
    Data_Q  = $urandom;
    exp_b   = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    exp_b2  = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    for (int i = 0; i < 4; i++) begin
      chk("single_valid", {31'd0, B_VALID}, 32'd1);
      chk("single_byte", {24'd0, BYTE_OUT}, {24'd0, exp_b[i]});
      chk("single_byte_msb", {24'd0, BYTE_OUT2}, {24'd0, exp_b2[i]});
      tick();
    end
    chk("single_done_valid", {31'd0, B_VALID}, 32'd0);
    chk("single_done_cnt", {16'd0, WORD_CNT}, 32'd1);
    chk("single_done_busy", {31'd0, BUSY}, 32'd0);

    // Back-to-back stream of three words.
    w[0] = 32'h03020100;
    w[1] = 32'h07060504;
    w[2] = 32'h0B0A0908;
    Data_Q  = w[0];
    Q_VALID = 1'b1;
    tick();
    k      = 1;
    Data_Q = w[1];
    for (int n = 0; n < 12; n++) begin
      chk("stream_valid", {31'd0, B_VALID}, 32'd1);
      chk("stream_byte", {24'd0, BYTE_OUT}, n);
      acc = Q_VALID && Q_READY;
      tick();
      if (acc) begin
        k++;
        if (k < 3) Data_Q = w[k];
        else Q_VALID = 1'b0;
      end
    end
    chk("stream_end_valid", {31'd0, B_VALID}, 32'd0);
    chk("stream_cnt", {16'd0, WORD_CNT}, 32'd4);
    chk("stream_cnt_wrap", {30'd0, WORD_CNT2}, 32'd0);

    // Backpressure at lane 2 with a second word landing in the prefetch.
    Data_Q  = 32'h44332211;
    Q_VALID = 1'b1;
    tick();
    Q_VALID = 1'b0;
    chk("bp_b0", {24'd0, BYTE_OUT}, 32'h11);
    tick();
    chk("bp_b1", {24'd0, BYTE_OUT}, 32'h22);
    tick();
    chk("bp_b2", {24'd0, BYTE_OUT}, 32'h33);
    B_READY = 1'b0;
    Data_Q  = 32'h88776655;
    Q_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      Q_VALID = 1'b0;
      chk("bp_hold_byte", {24'd0, BYTE_OUT}, 32'h33);
      chk("bp_hold_valid", {31'd0, B_VALID}, 32'd1);
      chk("bp_hold_qready", {31'd0, Q_READY}, 32'd0);
    end
    B_READY = 1'b1;
    tick();
    chk("bp_b3", {24'd0, BYTE_OUT}, 32'h44);
    chk("bp_b3_qready", {31'd0, Q_READY}, 32'd0);
    tick();
    chk("bp_pf_b0", {24'd0, BYTE_OUT}, 32'h55);
    chk("bp_pf_qready", {31'd0, Q_READY}, 32'd1);
    tick();
    chk("bp_pf_b1", {24'd0, BYTE_OUT}, 32'h66);
    tick();
    chk("bp_pf_b2", {24'd0, BYTE_OUT}, 32'h77);
    tick();
    chk("bp_pf_b3", {24'd0, BYTE_OUT}, 32'h88);
    tick();
    chk("bp_end_valid", {31'd0, B_VALID}, 32'd0);
    chk("bp_cnt", {16'd0, WORD_CNT}, 32'd6);

    // MSB-first ordering on the second instance.
    Data_Q  = 32'h11223344;
    Q_VALID = 1'b1;
    tick();
    Q_VALID = 1'b0;
    exp_b2  = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      chk("msb_byte", {24'd0, BYTE_OUT2}, {24'd0, exp_b2[i]});
      tick();
    end
    chk("msb_cnt2", {30'd0, WORD_CNT2}, 32'd3);

    // Reset in mid-word with the prefetch occupied.
    Data_Q  = 32'hDEADBEEF;
    Q_VALID = 1'b1;
    tick();
    chk("rw_b0", {24'd0, BYTE_OUT}, 32'hEF);
    Data_Q = 32'h12345678;
    tick();
    Q_VALID = 1'b0;
    chk("rw_b1", {24'd0, BYTE_OUT}, 32'hBE);
    tick();
    chk("rw_b2", {24'd0, BYTE_OUT}, 32'hAD);
    chk("rw_pf_full", {31'd0, Q_READY}, 32'd0);
    #2;
    RST = 1'b0;
    #1;
    chk("rw_async_valid", {31'd0, B_VALID}, 32'd0);
    chk("rw_async_qready", {31'd0, Q_READY}, 32'd0);
    chk("rw_async_busy", {31'd0, BUSY}, 32'd0);
    chk("rw_async_cnt", {16'd0, WORD_CNT}, 32'd0);
    tick();
    tick();
    RST = 1'b1;
    tick();
    chk("rw_rel_qready", {31'd0, Q_READY}, 32'd1);
    chk("rw_rel_valid", {31'd0, B_VALID}, 32'd0);
    Data_Q  = 32'h55667788;
    Q_VALID = 1'b1;
    tick();
    Q_VALID = 1'b0;
    exp_b   = '{8'h88, 8'h77, 8'h66, 8'h55};
    for (int i = 0; i < 4; i++) begin
      chk("rw_new_byte", {24'd0, BYTE_OUT}, {24'd0, exp_b[i]});
      tick();
    end
    chk("rw_new_valid", {31'd0, B_VALID}, 32'd0);
    chk("rw_new_cnt", {16'd0, WORD_CNT}, 32'd1);

    // Randomized traffic; Data_Q carries garbage whenever Q_VALID is low.
    for (int i = 0; i < 3000; i++) begin
      Q_VALID = ($urandom % 3) != 0;
      Data_Q  = $urandom;
      B_READY = ($urandom % 4) != 0;
      if (i == 1500) begin
        #2;
        RST = 1'b0;
        tick();
        tick();
        RST = 1'b1;
      end
      tick();
    end
    Q_VALID = 1'b0;
    B_READY = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("drain_valid", {31'd0, B_VALID}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
